// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Covers controller states, decoded opcodes and IF/ID instruction field positions.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALT     = 3'd4
  } ctrl_state_t;

  localparam logic [3:0]  OP_HALT  = 4'b0000;
  localparam logic [3:0]  OP_JUMP  = 4'b0010;
  localparam logic [15:0] NOP_INST = 16'h8040;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RI_HI  = 11;
  localparam int RI_LO  = 10;
  localparam int RJ_HI  = 9;
  localparam int RJ_LO  = 8;
  localparam int WIN_HI = 1;
  localparam int WIN_LO = 0;

  function automatic logic [3:0] opcode_of(input logic [15:0] inst);
    return inst[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [1:0] window_of(input logic [15:0] inst);
    return inst[WIN_HI:WIN_LO];
  endfunction

  function automatic logic is_nop(input logic [15:0] inst);
    return inst == NOP_INST;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// A hazard only exists when both instructions sit in the same register window.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [1:0] ex_rd,
  input  logic [1:0] ex_window,
  input  logic [1:0] id_ri,
  input  logic [1:0] id_rj,
  input  logic       id_uses_rj,
  input  logic [1:0] id_window,
  output logic       load_use
);

  logic same_window;
  logic ri_match;
  logic rj_match;

  assign same_window = (ex_window == id_window);
  assign ri_match    = (ex_rd == id_ri);
  assign rj_match    = id_uses_rj && (ex_rd == id_rj);
  assign load_use    = ex_memread && same_window && (ri_match || rj_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage windowed-register pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUB = 1,
  parameter int DRAIN_CYC    = 3,
  parameter int MEM_TIMEOUT  = 15
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] id_inst,
  input  logic        id_uses_rj,
  input  logic [1:0]  id_window,
  input  logic        ex_memread,
  input  logic [1:0]  ex_rd,
  input  logic [1:0]  ex_window,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        resume,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] RED_EXTRA  = 2'(REDIRECT_BUB - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);
  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT);

  ctrl_state_t state, state_next;
  ctrl_state_t ret_state, ret_next;
  ctrl_state_t eff_state;
  logic [1:0]  red_left, red_next;
  logic [3:0]  drain_cnt, drain_next;
  logic [3:0]  wait_cnt;
  logic        lu_block, lu_next;
  logic        mem_err_q;
  logic        load_use;
  logic        mem_stall;
  logic        mem_wait_act;
  logic        redirect_req;
  logic        halt_req;
  logic        id_unused;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .ex_window  (ex_window),
    .id_ri      (id_inst[RI_HI:RI_LO]),
    .id_rj      (id_inst[RJ_HI:RJ_LO]),
    .id_uses_rj (id_uses_rj),
    .id_window  (id_window),
    .load_use   (load_use)
  );

  assign id_unused    = ^id_inst[7:0];
  assign mem_stall    = mem_req && !mem_ready;
  assign redirect_req = branch_taken || (opcode_of(id_inst) == OP_JUMP);
  assign halt_req     = (opcode_of(id_inst) == OP_HALT);

  // While waiting on memory, the interrupted state decides what happens once data arrives.
  assign eff_state    = (state == ST_MEM_WAIT) ? ret_state : state;
  assign mem_wait_act = mem_stall && (eff_state != ST_HALT);
  assign mem_err      = mem_err_q;

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    state_next   = state;
    ret_next     = ret_state;
    red_next     = red_left;
    drain_next   = drain_cnt;
    lu_next      = 1'b0;
    if (rst_n) begin
      if (mem_wait_act) begin
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
        state_next   = ST_MEM_WAIT;
        ret_next     = (eff_state == ST_DRAIN) ? ST_DRAIN : ST_RUN;
        lu_next      = lu_block;
      end else begin
        unique case (eff_state)
          ST_RUN: begin
            state_next = ST_RUN;
            // The bubble reaches EX on the next edge, so one hold cycle always suffices.
            if (load_use && !lu_block) begin
              pc_hold     = 1'b1;
              ifid_hold   = 1'b1;
              idex_bubble = 1'b1;
              lu_next     = 1'b1;
            end else if (redirect_req) begin
              ifid_flush = 1'b1;
              if (RED_EXTRA != 2'd0) begin
                state_next = ST_REDIRECT;
                red_next   = RED_EXTRA - 2'd1;
              end
            end else if (halt_req) begin
              pc_hold    = 1'b1;
              ifid_flush = 1'b1;
              state_next = ST_DRAIN;
              drain_next = 4'd0;
            end
          end
          ST_REDIRECT: begin
            ifid_flush = 1'b1;
            if (red_left == 2'd0) begin
              state_next = ST_RUN;
            end else begin
              state_next = ST_REDIRECT;
              red_next   = red_left - 2'd1;
            end
          end
          ST_DRAIN: begin
            pc_hold = 1'b1;
            if (drain_cnt == DRAIN_LAST) begin
              state_next = ST_HALT;
            end else begin
              state_next = ST_DRAIN;
              drain_next = drain_cnt + 4'd1;
            end
          end
          ST_HALT: begin
            halted     = 1'b1;
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            exmem_hold = 1'b1;
            state_next = resume ? ST_RUN : ST_HALT;
          end
          default: begin
            state_next = ST_RUN;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      red_left  <= 2'd0;
      drain_cnt <= 4'd0;
      lu_block  <= 1'b0;
      wait_cnt  <= 4'd0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      ret_state <= ret_next;
      red_left  <= red_next;
      drain_cnt <= drain_next;
      lu_block  <= lu_next;
      if (mem_wait_act) begin
        if (wait_cnt != WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        if (wait_cnt >= WAIT_LIMIT - 4'd1) begin
          mem_err_q <= 1'b1;
        end
      end else begin
        wait_cnt <= 4'd0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (pc_hold && !halted && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (ifid_flush && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REDIRECT_BUB=2) with hand-computed control vectors.
// Control vector order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, halted, mem_err}.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id_inst;
  logic        id_uses_rj;
  logic [1:0]  id_window;
  logic        ex_memread;
  logic [1:0]  ex_rd;
  logic [1:0]  ex_window;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        resume;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_hold;
  logic        memwb_bubble;
  logic        halted;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [7:0]  ctrl;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_stall    = 0;
  int exp_flush    = 0;

  pipeline_hazard_ctrl #(
    .REDIRECT_BUB (2),
    .DRAIN_CYC    (3),
    .MEM_TIMEOUT  (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_inst      (id_inst),
    .id_uses_rj   (id_uses_rj),
    .id_window    (id_window),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .ex_window    (ex_window),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_bubble,
                 exmem_hold, memwb_bubble, halted, mem_err};

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for the falling edge, then return every input to an idle RUN-cycle value.
  task automatic applyStimulus();
    @(negedge clk);
    id_inst      = 16'h8040;
    id_uses_rj   = 1'b0;
    id_window    = 2'd0;
    ex_memread   = 1'b0;
    ex_rd        = 2'd0;
    ex_window    = 2'd0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    resume       = 1'b0;
  endtask

  task automatic checkCycle(input string tag, input logic [7:0] exp);
    #1;
    checkOutput(tag, {8'h00, ctrl}, {8'h00, exp});
    if (exp[7] && !exp[1]) exp_stall++;
    if (exp[5]) exp_flush++;
  endtask

  task automatic loadUse(input logic [15:0] inst, input logic rj, input logic [1:0] rd,
                         input logic [1:0] exw, input logic [1:0] idw);
    id_inst    = inst;
    id_uses_rj = rj;
    ex_memread = 1'b1;
    ex_rd      = rd;
    ex_window  = exw;
    id_window  = idw;
  endtask

  initial begin
    rst_n        = 1'b0;
    id_inst      = 16'h8040;
    id_uses_rj   = 1'b0;
    id_window    = 2'd0;
    ex_memread   = 1'b0;
    ex_rd        = 2'd0;
    ex_window    = 2'd0;
    branch_taken = 1'b0;
    mem_req      = 1'b1;
    mem_ready    = 1'b0;
    resume       = 1'b0;
    #12;
    checkOutput("reset_ctrl", {8'h00, ctrl}, 16'h0000);
    checkOutput("reset_stall_cnt", stall_cnt, 16'h0000);
    checkOutput("reset_flush_cnt", flush_cnt, 16'h0000);

    applyStimulus(); rst_n = 1'b1;
    checkCycle("idle0", 8'h00);

    // Load-use on Ri, same window: one hold cycle even if inputs linger
    applyStimulus(); loadUse(16'h4400, 1'b0, 2'b01, 2'd2, 2'd2);
    checkCycle("lu_ri", 8'hD0);
    applyStimulus(); loadUse(16'h4400, 1'b0, 2'b01, 2'd2, 2'd2);
    checkCycle("lu_once", 8'h00);
    applyStimulus();
    checkCycle("lu_idle", 8'h00);

    applyStimulus(); loadUse(16'h4100, 1'b1, 2'b01, 2'd1, 2'd1);
    checkCycle("lu_rj", 8'hD0);
    applyStimulus();
    checkCycle("lu_rj_idle", 8'h00);
    applyStimulus(); loadUse(16'h4100, 1'b0, 2'b01, 2'd1, 2'd1);
    checkCycle("lu_rj_unused", 8'h00);

    applyStimulus(); loadUse(16'h4400, 1'b0, 2'b01, 2'd1, 2'd2);
    checkCycle("lu_win_mismatch", 8'h00);

    // Taken branch flushes twice, then back to RUN
    applyStimulus(); branch_taken = 1'b1;
    checkCycle("br_flush0", 8'h20);
    applyStimulus();
    checkCycle("br_flush1", 8'h20);
    applyStimulus();
    checkCycle("br_done", 8'h00);

    applyStimulus(); id_inst = 16'h2000;
    checkCycle("jmp_flush0", 8'h20);
    applyStimulus();
    checkCycle("jmp_flush1", 8'h20);
    applyStimulus();
    checkCycle("jmp_done", 8'h00);

    // Load-use beats redirect; redirect is taken the following cycle
    applyStimulus(); loadUse(16'h4400, 1'b0, 2'b01, 2'd3, 2'd3); branch_taken = 1'b1;
    checkCycle("lu_over_br", 8'hD0);
    applyStimulus(); loadUse(16'h4400, 1'b0, 2'b01, 2'd3, 2'd3); branch_taken = 1'b1;
    checkCycle("br_after_lu0", 8'h20);
    applyStimulus();
    checkCycle("br_after_lu1", 8'h20);
    applyStimulus();
    checkCycle("br_after_lu_done", 8'h00);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(); mem_req = 1'b1;
      checkCycle($sformatf("memwait_%0d", k), 8'hCC);
    end
    applyStimulus(); mem_req = 1'b1; mem_ready = 1'b1;
    checkCycle("memwait_done", 8'h00);

    applyStimulus(); resume = 1'b1;
    checkCycle("resume_in_run", 8'h00);

    // HALT: decode, three drain cycles, then frozen until resume
    applyStimulus(); id_inst = 16'h0000;
    checkCycle("halt_decode", 8'hA0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus();
      checkCycle($sformatf("drain_%0d", k), 8'h80);
    end
    applyStimulus();
    checkCycle("halted", 8'hCA);
    applyStimulus(); resume = 1'b1;
    checkCycle("halt_resume", 8'hCA);
    applyStimulus();
    checkCycle("after_resume", 8'h00);

    // Memory wait inside DRAIN keeps the drain count
    applyStimulus(); id_inst = 16'h0000;
    checkCycle("halt2_decode", 8'hA0);
    applyStimulus();
    checkCycle("halt2_drain1", 8'h80);
    applyStimulus(); mem_req = 1'b1;
    checkCycle("halt2_wait1", 8'hCC);
    applyStimulus(); mem_req = 1'b1;
    checkCycle("halt2_wait2", 8'hCC);
    applyStimulus(); mem_req = 1'b1; mem_ready = 1'b1;
    checkCycle("halt2_drain2", 8'h80);
    applyStimulus();
    checkCycle("halt2_drain3", 8'h80);
    applyStimulus();
    checkCycle("halt2_halted", 8'hCA);
    applyStimulus(); mem_req = 1'b1;
    checkCycle("halt2_memreq_ignored", 8'hCA);
    applyStimulus(); resume = 1'b1;
    checkCycle("halt2_resume", 8'hCA);
    applyStimulus();
    checkCycle("halt2_run", 8'h00);

    // Timeout: mem_err becomes visible after the 15th wait cycle
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(); mem_req = 1'b1;
      checkCycle($sformatf("timeout_%0d", k), (k == 16) ? 8'hCD : 8'hCC);
    end
    applyStimulus(); mem_req = 1'b1; mem_ready = 1'b1;
    checkCycle("timeout_release", 8'h01);

    applyStimulus();
`ifdef PIPE_PERF_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 16'(exp_stall));
    checkOutput("flush_cnt", flush_cnt, 16'(exp_flush));
`else
    checkOutput("stall_cnt_tied", stall_cnt, 16'h0000);
    checkOutput("flush_cnt_tied", flush_cnt, 16'h0000);
`endif
    checkCycle("err_sticky", 8'h01);

    // Asynchronous reset in the middle of a memory wait
    applyStimulus(); mem_req = 1'b1;
    checkCycle("prereset_wait", 8'hCD);
    applyStimulus(); mem_req = 1'b1; rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {8'h00, ctrl}, 16'h0000);
    checkOutput("async_reset_stall_cnt", stall_cnt, 16'h0000);
    checkOutput("async_reset_flush_cnt", flush_cnt, 16'h0000);
    applyStimulus(); rst_n = 1'b1;
    checkCycle("post_reset_idle", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
